core_mem_ctrl: RTL and testbench
================================

// Module: core_mem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of Core's M port. It consumes enable_M/addr_M/wr_data_M
//  and returns rd_data_M/ready_M from a local single-port scratchpad with fixed read and write latency.
//  A host port lets the bench or dispatcher preload and dump the scratchpad while Core is idle.
// PARAMETERS
//  DATA_W  8  width of a memory word; equals the Core register width
//  ADDR_W  8  address width; depth = 2**ADDR_W words
//  RD_LAT  2  read busy cycles, >=1
//  WR_LAT  1  write busy cycles, >=1
// PORTS
//  clk          in   1       clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  enable_M     in   2       00 idle, 01 read, 10 write, 11 illegal
//  addr_M       in   ADDR_W  Core word address
//  wr_data_M    in   DATA_W  Core write data
//  rd_data_M    out  DATA_W  read result; holds last read value
//  ready_M      out  1       1 = controller free / previous op done
//  err_M        out  1       sticky: illegal enable code seen
//  host_sel     in   1       host requests ownership of the array
//  host_grant   out  1       host owns the array
//  host_we      in   1       host write strobe, honoured only while host_grant
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_rdata   out  DATA_W  registered read of host_addr, 1-cycle latency
// BEHAVIOUR
//  Reset values: ready_M=1, rd_data_M=0, err_M=0, host_grant=0, host_rdata=0, FSM=IDLE, cnt=0.
//   Array contents are not cleared.
//  Core accept: at an edge where state is IDLE or DONE, host_sel=0, and enable_M is 01 or 10:
//   latch addr/data/op, load cnt with RD_LAT or WR_LAT, go to BUSY, and drive ready_M=0.
//  BUSY: cnt decrements each cycle. Next edge after cnt reaches 1, the op completes:
//   read: rd_data_M <= mem[addr]. write: mem[addr] <= data.
//   Then ready_M=1 and the FSM goes to DONE.
//  Latency: read accepted at edge T0 gives ready_M=0 for edges T0+1..T0+RD_LAT;
//   ready_M=1 with valid data at edge T0+RD_LAT+1. Writes follow the same rule with WR_LAT.
//  DONE is identical to IDLE, except it marks a completion cycle. A new request present in DONE is
//   accepted on that edge (back-to-back), so Core must drop enable_M in its ready_M cycle unless it is
//   issuing a new op. With no request, DONE -> IDLE.
//  enable_M=11 in IDLE/DONE: no access, err_M <= 1 (sticky until reset), ready_M stays 1.
//  enable_M is ignored while BUSY; latched addr/data are used even if Core changes its inputs.
//  Host arbitration:
//   - host_sel=1 in IDLE/DONE: host_grant <= 1 next edge, FSM -> HOST, ready_M <= 0.
//     Core requests are not accepted.
//   - host_sel=1 while BUSY: the in-flight op completes first, then HOST.
//     No new Core op is accepted at that completion edge.
//   - HOST: host_we writes mem[host_addr] each edge; host_rdata <= mem[host_addr] each edge
//     (read-before-write on the same address).
//   - host_sel=0 in HOST: host_grant <= 0, FSM -> IDLE, ready_M <= 1.
//  Address wrap is implicit: depth is 2**ADDR_W, so every address is in range.
//  Reset mid-op: the in-flight op is dropped with no array write; outputs return to reset values.
// STRUCTURE
//  Shared defines header, included by Core and this block:
//   MEM_EN_IDLE=2'b00, MEM_EN_RD=2'b01, MEM_EN_WR=2'b10, MEM_EN_BAD=2'b11; FSM state encodings.
//  FSM states: IDLE, BUSY, DONE, HOST. cnt is a down-counter sized for max(RD_LAT, WR_LAT).
//  Sub-module core_mem_array:
//   single-port synchronous RAM (we, addr, wdata, registered rdata). This block muxes Core and host onto it.
// TESTING
//  1 Host preload: host_sel=1, write 0x11..0x14 to addr 0..3, read back -> host_rdata 0x11..0x14.
//  2 Core read, RD_LAT=2: read addr 2 at T0 -> ready_M low 2 cycles, high at T0+3, rd_data_M=0x13.
//  3 Back-to-back: write 0xAA@5, then read@5 issued in the DONE cycle -> rd_data_M=0xAA,
//    no idle cycle between the two ops.
//  4 Illegal: enable_M=11 -> err_M=1 and stays 1, array unchanged, ready_M=1; reset clears err_M.
//  5 host_sel raised mid-read -> read completes with correct data, then host_grant=1,
//    Core write ignored until host_sel=0.
//  6 Reset during BUSY write of 0x55@7 -> host dump shows mem[7] unchanged; ready_M=1 after reset.

Source files
------------

// File: rtl/core_mem_ctrl_pkg.sv
// Shared types and constants for the Core data-memory controller.
// Enable codes are shared with Core's M stage.
package core_mem_ctrl_pkg;

   localparam logic [1:0] MEM_EN_IDLE = 2'b00;
   localparam logic [1:0] MEM_EN_RD   = 2'b01;
   localparam logic [1:0] MEM_EN_WR   = 2'b10;
   localparam logic [1:0] MEM_EN_BAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2,
      ST_HOST = 2'd3
   } mem_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/core_mem_array.sv
// Single-port synchronous scratchpad RAM.
// Registered read returns the pre-write contents on a same-address write.
module core_mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/core_mem_ctrl.sv
// Data-memory controller behind Core's M port, with fixed-latency
// access to a local scratchpad and a host port for preload/dump.
module core_mem_ctrl
   import core_mem_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        enable_M,
   input  logic [ADDR_W-1:0] addr_M,
   input  logic [DATA_W-1:0] wr_data_M,
   output logic [DATA_W-1:0] rd_data_M,
   output logic              ready_M,
   output logic              err_M,
   input  logic              host_sel,
   output logic              host_grant,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata
);

   localparam int MAX_LAT = max_int(RD_LAT, WR_LAT);
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mem_state_e        state_q, state_n;
   mem_op_e           op_q, op_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic [DATA_W-1:0] rd_data_q, rd_data_n;
   logic              ready_q, ready_n;
   logic              err_q, err_n;
   logic              grant_q, grant_n;
   logic              host_rd_q;
   logic [DATA_W-1:0] host_hold_q;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   core_mem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .addr (arr_addr),
      .wdata(arr_wdata),
      .rdata(arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_RD;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         rd_data_q   <= '0;
         ready_q     <= 1'b1;
         err_q       <= 1'b0;
         grant_q     <= 1'b0;
         host_rd_q   <= 1'b0;
         host_hold_q <= '0;
      end else begin
         state_q   <= state_n;
         op_q      <= op_n;
         cnt_q     <= cnt_n;
         addr_q    <= addr_n;
         data_q    <= data_n;
         rd_data_q <= rd_data_n;
         ready_q   <= ready_n;
         err_q     <= err_n;
         grant_q   <= grant_n;
         host_rd_q <= (state_q == ST_HOST);
         if (host_rd_q) begin
            host_hold_q <= arr_rdata;
         end
      end
   end

   // The array reads addr_M while idle, so a read's data is already
   // registered one edge after accept; this keeps RD_LAT=1 legal.
   always_comb begin
      state_n   = state_q;
      op_n      = op_q;
      cnt_n     = cnt_q;
      addr_n    = addr_q;
      data_n    = data_q;
      rd_data_n = rd_data_q;
      ready_n   = ready_q;
      err_n     = err_q;
      grant_n   = grant_q;
      arr_we    = 1'b0;
      arr_addr  = addr_M;
      arr_wdata = data_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            priority case (1'b1)
               host_sel: begin
                  state_n = ST_HOST;
                  grant_n = 1'b1;
                  ready_n = 1'b0;
               end
               (enable_M == MEM_EN_RD): begin
                  state_n = ST_BUSY;
                  op_n    = OP_RD;
                  cnt_n   = CNT_W'(RD_LAT);
                  addr_n  = addr_M;
                  ready_n = 1'b0;
               end
               (enable_M == MEM_EN_WR): begin
                  state_n = ST_BUSY;
                  op_n    = OP_WR;
                  cnt_n   = CNT_W'(WR_LAT);
                  addr_n  = addr_M;
                  data_n  = wr_data_M;
                  ready_n = 1'b0;
               end
               (enable_M == MEM_EN_BAD): begin
                  err_n = 1'b1;
               end
               default: begin
               end
            endcase
         end
         ST_BUSY: begin
            arr_addr = addr_q;
            if (cnt_q == CNT_W'(1)) begin
               cnt_n  = '0;
               arr_we = (op_q == OP_WR) && !reset;
               if (op_q == OP_RD) begin
                  rd_data_n = arr_rdata;
               end
               if (host_sel) begin
                  state_n = ST_HOST;
                  grant_n = 1'b1;
                  ready_n = 1'b0;
               end else begin
                  state_n = ST_DONE;
                  ready_n = 1'b1;
               end
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_HOST: begin
            arr_addr  = host_addr;
            arr_wdata = host_wdata;
            arr_we    = host_we && !reset;
            if (!host_sel) begin
               state_n = ST_IDLE;
               grant_n = 1'b0;
               ready_n = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign rd_data_M  = rd_data_q;
   assign ready_M    = ready_q;
   assign err_M      = err_q;
   assign host_grant = grant_q;
   assign host_rdata = host_rd_q ? arr_rdata : host_hold_q;

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Directed plus randomized bench for core_mem_ctrl against
// a word-array reference model of the scratchpad.
module tb_core_mem_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        enable_M;
   logic [ADDR_W-1:0] addr_M;
   logic [DATA_W-1:0] wr_data_M;
   logic [DATA_W-1:0] rd_data_M;
   logic              ready_M;
   logic              err_M;
   logic              host_sel;
   logic              host_grant;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [DATA_W-1:0] host_rdata;

   logic [DATA_W-1:0] model [2**ADDR_W];
   logic [DATA_W-1:0] last_rd;
   int                n_vec = 0;
   int                n_bad = 0;

   core_mem_ctrl #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .RD_LAT(RD_LAT),
      .WR_LAT(WR_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable_M  (enable_M),
      .addr_M    (addr_M),
      .wr_data_M (wr_data_M),
      .rd_data_M (rd_data_M),
      .ready_M   (ready_M),
      .err_M     (err_M),
      .host_sel  (host_sel),
      .host_grant(host_grant),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_wdata(host_wdata),
      .host_rdata(host_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Core op from IDLE/DONE; latency and result checked from the model.
   task automatic core_op(input bit wr, input logic [7:0] a,
                          input logic [7:0] d);
      int lat;
      lat       = wr ? WR_LAT : RD_LAT;
      enable_M  = wr ? 2'b10 : 2'b01;
      addr_M    = a;
      wr_data_M = d;
      tick();
      enable_M  = 2'b00;
      addr_M    = 8'($urandom);
      wr_data_M = 8'($urandom);
      for (int i = 0; i < lat; i++) begin
         chk("busy_ready", 32'(ready_M), 32'd0);
         tick();
      end
      chk("done_ready", 32'(ready_M), 32'd1);
      if (wr) begin
         model[a] = d;
         chk("rd_hold", 32'(rd_data_M), 32'(last_rd));
      end else begin
         last_rd = model[a];
         chk("rd_data", 32'(rd_data_M), 32'(model[a]));
      end
   endtask

   task automatic host_read(input logic [7:0] a, input string tag);
      host_we   = 1'b0;
      host_addr = a;
      tick();
      chk(tag, 32'(host_rdata), 32'(model[a]));
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] old;
      bit         seen;
      reset      = 1'b1;
      enable_M   = 2'b00;
      addr_M     = '0;
      wr_data_M  = '0;
      host_sel   = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      last_rd    = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready", 32'(ready_M), 32'd1);
      chk("rst_rd_data", 32'(rd_data_M), 32'd0);
      chk("rst_err", 32'(err_M), 32'd0);
      chk("rst_grant", 32'(host_grant), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);

      // Host preload of the whole array
      host_sel = 1'b1;
      tick();
      chk("host_grant", 32'(host_grant), 32'd1);
      chk("host_ready", 32'(ready_M), 32'd0);
      for (int i = 0; i < 2**ADDR_W; i++) begin
         host_we   = 1'b1;
         host_addr = 8'(i);
         if (i < 4)       host_wdata = 8'(8'h11 + i);
         else if (i == 7) host_wdata = 8'h77;
         else             host_wdata = 8'($urandom);
         model[i] = host_wdata;
         tick();
      end
      for (int i = 0; i < 4; i++) host_read(8'(i), "host_preload");
      for (int i = 0; i < 4; i++) host_read(8'($urandom), "host_rand_rd");
      old        = model[9];
      host_we    = 1'b1;
      host_addr  = 8'd9;
      host_wdata = ~old;
      tick();
      chk("host_rbw", 32'(host_rdata), 32'(old));
      model[9] = ~old;
      host_read(8'd9, "host_after_wr");
      host_sel = 1'b0;
      host_we  = 1'b0;
      tick();
      chk("host_release", 32'(host_grant), 32'd0);
      chk("release_ready", 32'(ready_M), 32'd1);

      // Core read with latency
      core_op(1'b0, 8'd2, 8'h00);
      chk("read_0x13", 32'(rd_data_M), 32'h13);

      // Back-to-back write then read in the DONE cycle
      core_op(1'b1, 8'd5, 8'hAA);
      core_op(1'b0, 8'd5, 8'h00);
      chk("b2b_0xAA", 32'(rd_data_M), 32'hAA);

      // Randomized Core traffic
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         d = 8'($urandom);
         core_op(1'($urandom), a, d);
         if ($urandom_range(0, 2) == 0) tick();
      end

      // Illegal enable code
      enable_M = 2'b11;
      addr_M   = 8'd3;
      tick();
      chk("bad_err", 32'(err_M), 32'd1);
      chk("bad_ready", 32'(ready_M), 32'd1);
      enable_M = 2'b00;
      tick();
      tick();
      chk("bad_sticky", 32'(err_M), 32'd1);
      core_op(1'b0, 8'd3, 8'h00);
      chk("bad_err_after_op", 32'(err_M), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("bad_err_reset", 32'(err_M), 32'd0);
      last_rd = '0;

      // host_sel raised during a read, Core write attempted meanwhile
      a = 8'd2;
      enable_M = 2'b01;
      addr_M   = a;
      tick();
      enable_M  = 2'b10;
      addr_M    = a;
      wr_data_M = ~model[a];
      host_sel  = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = host_grant;
      end
      chk("mid_grant_seen", 32'(seen), 32'd1);
      chk("mid_rd_data", 32'(rd_data_M), 32'(model[a]));
      tick();
      tick();
      chk("mid_ready_low", 32'(ready_M), 32'd0);
      host_read(a, "mid_no_core_wr");
      enable_M = 2'b00;
      tick();
      host_sel = 1'b0;
      tick();
      chk("mid_release", 32'(host_grant), 32'd0);
      core_op(1'b0, a, 8'h00);

      // Reset during a busy write
      enable_M  = 2'b10;
      addr_M    = 8'd7;
      wr_data_M = 8'h55;
      tick();
      enable_M = 2'b00;
      chk("rstw_busy", 32'(ready_M), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstw_ready", 32'(ready_M), 32'd1);
      chk("rstw_rd_data", 32'(rd_data_M), 32'd0);
      host_sel = 1'b1;
      tick();
      host_read(8'd7, "rstw_mem7");
      chk("rstw_mem7_val", 32'(host_rdata), 32'h77);
      host_sel = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
